mem_rr_scheduler: RTL

- Shares one two-stage registered memory word-path among NUM_REQ requesters.
- The memory captures its input on one clock edge and presents it on the output one edge later.
- Arbitration is round-robin with bounded bursts: a requester may keep the grant for up to MAX_BURST consecutive transfers.
- A tag pipeline runs alongside the memory path so each word returns with its requester ID, aligned to the memory output.
- Sits between the requester ports and the memory instance, which shares clk and reset.

---
 rtl/mem_rr_scheduler_if.sv | 31 +++
 rtl/mem_rr_scheduler.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_scheduler_if
//  Description : Requester, memory and response bundle of mem_rr_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_rr_scheduler_if #(
    parameter int WORD_SIZE = 4,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*WORD_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [WORD_SIZE-1:0]         mem_data_in;
    logic [WORD_SIZE-1:0]         mem_data_out;
    logic                         rsp_valid;
    logic [ID_WIDTH-1:0]          rsp_id;
    logic [WORD_SIZE-1:0]         rsp_data;

    modport master (
        output req_valid, req_data, mem_data_out,
        input  req_ready, mem_data_in, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data, mem_data_out,
        output req_ready, mem_data_in, rsp_valid, rsp_id, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_scheduler
//  Description : Round-robin, burst-bounded arbiter in front of a two-stage
//                registered memory, returning each word tagged with its ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_scheduler #(
    parameter int WORD_SIZE = 4,
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int MAX_BURST = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_rr_scheduler_if.slave bus
);
    localparam int                c_CW        = $clog2(MAX_BURST + 1);
    localparam logic [c_CW-1:0]   c_CNT_ONE   = c_CW'(1);
    localparam logic [c_CW-1:0]   c_CNT_MAX   = c_CW'(MAX_BURST);
    localparam logic [ID_WIDTH-1:0] c_LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    logic [0:0]          r_state, w_state_nxt;
    logic [ID_WIDTH-1:0] r_ptr, w_ptr_nxt;
    logic [ID_WIDTH-1:0] r_owner, w_owner_nxt;
    logic [c_CW-1:0]     r_count, w_count_nxt;

    logic [ID_WIDTH-1:0] w_scan_start;
    logic [ID_WIDTH-1:0] w_cand;
    logic                w_scan_hit;
    logic [ID_WIDTH-1:0] w_scan_id;
    logic                w_keep;
    logic                w_gnt;
    logic [ID_WIDTH-1:0] w_gnt_id;

    logic                r_tag1_valid, r_tag2_valid;
    logic [ID_WIDTH-1:0] r_tag1_id, r_tag2_id;

    // IDs wrap at NUM_REQ, which need not be a power of two
    function automatic logic [ID_WIDTH-1:0] f_next(input logic [ID_WIDTH-1:0] x);
        return (x == c_LAST_ID) ? '0 : x + 1'b1;
    endfunction

    function automatic logic [ID_WIDTH-1:0] f_wrap(input int x);
        return (x >= NUM_REQ) ? ID_WIDTH'(x - NUM_REQ) : ID_WIDTH'(x);
    endfunction

    always_comb begin
        w_scan_start = (r_state == c_BURST) ? f_next(r_owner) : r_ptr;
        w_scan_hit   = 1'b0;
        w_scan_id    = '0;
        w_cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = f_wrap(int'(w_scan_start) + i);
            if (!w_scan_hit && bus.req_valid[w_cand]) begin
                w_scan_hit = 1'b1;
                w_scan_id  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_count_nxt = r_count;
        w_gnt       = 1'b0;
        w_gnt_id    = '0;
        w_keep      = (r_state == c_BURST) && bus.req_valid[r_owner];
        // No grants are issued while the block is held in reset
        if (reset) begin
            if (w_keep) begin
                w_gnt    = 1'b1;
                w_gnt_id = r_owner;
                if (r_count + c_CNT_ONE == c_CNT_MAX) begin
                    w_ptr_nxt   = f_next(r_owner);
                    w_count_nxt = '0;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end
            end else if (w_scan_hit) begin
                w_gnt       = 1'b1;
                w_gnt_id    = w_scan_id;
                w_owner_nxt = w_scan_id;
                w_count_nxt = c_CNT_ONE;
                if (MAX_BURST == 1) begin
                    w_ptr_nxt   = f_next(w_scan_id);
                    w_state_nxt = c_IDLE;
                end else begin
                    w_state_nxt = c_BURST;
                end
            end else if (r_state == c_BURST) begin
                w_ptr_nxt   = f_next(r_owner);
                w_count_nxt = '0;
                w_state_nxt = c_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        bus.req_ready   = '0;
        bus.mem_data_in = '0;
        if (w_gnt) begin
            bus.req_ready[w_gnt_id] = 1'b1;
            bus.mem_data_in         = bus.req_data[w_gnt_id*WORD_SIZE +: WORD_SIZE];
        end
    end

    // Two tag stages mirror the memory's capture/present latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag1_valid <= 1'b0;
            r_tag1_id    <= '0;
            r_tag2_valid <= 1'b0;
            r_tag2_id    <= '0;
        end else begin
            r_tag1_valid <= w_gnt;
            r_tag1_id    <= w_gnt_id;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_id    <= r_tag1_id;
        end
    end

    assign bus.rsp_valid = r_tag2_valid;
    assign bus.rsp_id    = r_tag2_id;
    assign bus.rsp_data  = bus.mem_data_out;
endmodule
`default_nettype wire
